hgcal_latent_deframer: RTL and testbench
========================================

HGCAL_LATENT_DEFRAMER -- requirements
Module: hgcal_latent_deframer

Interface
REQ-001 SHALL take parameter NEURONS, default 16: number of latent neuron codes per frame.
REQ-002 SHALL take parameter BW, default 2: bits per neuron code.
REQ-003 SHALL take parameter LANE_W, default 8: input beat width; NEURONS*BW SHALL be an integer multiple of LANE_W.
REQ-004 Ports (one clock; reset synchronous, active-low):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-low (asserted at 0).
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  LANE_W  packed codes; code k of the beat is s_data[k*BW +: BW].
- s_last  in  1  marks the final beat of a frame.
- m_valid  out  1  assembled frame valid.
- m_ready  in  1  frame consumed when m_valid && m_ready.
- m_data  out  NEURONS*BW  frame; neuron n is m_data[n*BW +: BW].
- frame_err  out  1  one-cycle pulse on a framing error.
- err_count  out  8  framing errors since reset, saturating.

Function
REQ-005 SHALL define BEATS = NEURONS*BW/LANE_W (4 at defaults).
REQ-006 Beat index i (0..BEATS-1) of a frame SHALL load m_data[i*LANE_W +: LANE_W]; neuron 0 arrives first, in the LSBs of beat 0.
REQ-007 SHALL implement the states IDLE, FILL, HOLD and RESYNC.
REQ-008 IDLE: s_ready=1; an accepted beat with s_last=0 stores beat 0 and moves to FILL, with beat counter = 1.
REQ-009 FILL: s_ready=1; each accepted beat stores at the counter index and increments the counter.
REQ-010 An accepted beat at index BEATS-1 with s_last=1 SHALL complete the frame; m_valid SHALL rise on the next cycle (latency 1 cycle from the final beat to m_valid); state becomes HOLD.
REQ-011 Early s_last (s_last=1 at index < BEATS-1, including beat 0 in IDLE) SHALL discard the partial frame, pulse frame_err on the next cycle, and return to IDLE.
REQ-012 Missing s_last (s_last=0 at index BEATS-1) SHALL discard the frame, pulse frame_err on the next cycle, and enter RESYNC.
REQ-013 RESYNC: s_ready=1; beats are dropped until an accepted beat with s_last=1, then the state returns to IDLE; no frame_err is raised for the dropped beats.
REQ-014 HOLD: m_data and m_valid SHALL stay stable while m_valid && !m_ready.
REQ-015 HOLD: on m_valid && m_ready, m_valid SHALL fall on the next cycle and the state returns to IDLE (unless REQ-023 applies).
REQ-016 err_count SHALL increment by 1 per frame_err pulse and saturate at 255.
REQ-017 s_ready SHALL depend only on registered state, never combinationally on m_ready.

Reset
REQ-018 While rst=0 at a rising clk edge: state=IDLE, beat counter=0, m_valid=0, m_data=0, frame_err=0, err_count=0.
REQ-019 s_ready SHALL be 0 while rst=0 and 1 on the first cycle after release.
REQ-020 Reset mid-frame or during HOLD SHALL discard all buffered data without raising frame_err.

Configuration
REQ-021 Macro HGCAL_LATENT_DEFRAMER_DOUBLE_BUF_EN SHALL select the buffering mode.
REQ-022 Without the macro (single buffer): s_ready=0 in HOLD; no beat is accepted until the held frame is consumed.
REQ-023 With the macro (double buffer): a second frame MAY fill while the first is held, and s_ready=0 only when both buffers are full. If the output is accepted and the second frame's final beat is accepted in the same cycle, m_valid SHALL stay 1 and m_data SHALL present the new frame on the next cycle. Frames SHALL be delivered in arrival order.

Structure
REQ-024 A shared package SHALL hold the state enum, the BEATS derivation function, and the ERR_CNT_W=8 constant.
REQ-025 With the macro, one sub-module hgcal_latent_frame_buf (one frame register plus full flag) SHALL be instantiated twice; without the macro, once.

Verification
REQ-026 Single frame, defaults: beats 0x1B, 0xE4, 0x00, 0xFF, last on beat 3, m_ready=1 -> m_valid 1 cycle after beat 3, m_data=0xFF00E41B, neuron 0 = 2'b11, frame_err never asserted.
REQ-027 Back-pressure: m_ready=0 for 10 cycles after m_valid -> m_data stable all 10 cycles. Without the macro, s_ready=0 throughout. With the macro, a second frame of 4 beats is accepted and delivered immediately after the first.
REQ-028 Early last: s_last on beat 1 -> frame_err pulses 1 cycle, err_count=1, no m_valid. A following valid frame 0x04030201 is delivered correctly.
REQ-029 Missing last: 6 beats with s_last only on beat 5 -> one frame_err, all 6 beats dropped, and the next 4-beat frame is delivered.
REQ-030 Saturation and reset: 300 early-last errors -> err_count=255. rst=0 for 1 cycle mid-frame -> err_count=0, m_valid=0, and the next frame is delivered intact.

Source files
------------

// File: rtl/hgcal_latent_deframer_pkg.sv
// Shared types and constants for the HGCAL latent-code deframer.
package hgcal_latent_deframer_pkg;

   // Input-side assembly states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      HOLD   = 2'd2,
      RESYNC = 2'd3
   } state_t;

   localparam int unsigned ERR_CNT_W = 8;

   // Number of input beats that make up one frame
   function automatic int unsigned beats_f(input int unsigned neurons,
                                           input int unsigned bw,
                                           input int unsigned lane_w);
      return (neurons * bw) / lane_w;
   endfunction

endpackage

// File: rtl/hgcal_latent_frame_buf.sv
// One frame register with a full flag; beats are written at a lane index.
module hgcal_latent_frame_buf #(
   parameter int unsigned LANE_W = 8,
   parameter int unsigned BEATS  = 4,
   parameter int unsigned CNT_W  = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en_i,
   input  logic [CNT_W-1:0]          wr_idx_i,
   input  logic [LANE_W-1:0]         wr_data_i,
   input  logic                      set_full_i,
   input  logic                      clr_full_i,
   output logic [LANE_W*BEATS-1:0]   frame_o,
   output logic                      full_o
);

   logic [LANE_W*BEATS-1:0] data_q, data_d;
   logic                    full_q;

   // Merge the incoming beat into its lane slot
   always_comb begin
      data_d = data_q;
      for (int unsigned b = 0; b < BEATS; b++) begin
         if (wr_en_i && (wr_idx_i == CNT_W'(b))) begin
            data_d[b*LANE_W +: LANE_W] = wr_data_i;
         end
      end
   end

   // Frame storage and full flag; set wins over clear
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         if (clr_full_i) full_q <= 1'b0;
         if (set_full_i) full_q <= 1'b1;
      end
   end

   assign frame_o = data_q;
   assign full_o  = full_q;

endmodule

// File: rtl/hgcal_latent_deframer.sv
// Reassembles LANE_W-bit beats into NEURONS*BW-bit latent frames.
// Optional macro HGCAL_LATENT_DEFRAMER_DOUBLE_BUF_EN adds a second frame
// buffer so a new frame can fill while the previous one is held.
module hgcal_latent_deframer
   import hgcal_latent_deframer_pkg::*;
#(
   parameter int unsigned NEURONS = 16,
   parameter int unsigned BW      = 2,
   parameter int unsigned LANE_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [LANE_W-1:0]      s_data,
   input  logic                   s_last,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [NEURONS*BW-1:0]  m_data,
   output logic                   frame_err,
   output logic [ERR_CNT_W-1:0]   err_count
);

   localparam int unsigned FRAME_W = NEURONS * BW;
   localparam int unsigned BEATS   = beats_f(NEURONS, BW, LANE_W);
   localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   rdy_q;
   logic                   err_q, err_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q;
   logic                   acc, pop, at_last;
   logic                   wr_en, cpl;
   logic                   tgt_busy_cpl, tgt_free_hold;

   assign acc     = s_valid && rdy_q;
   assign pop     = m_valid && m_ready;
   assign at_last = (cnt_q == LAST_IDX);

`ifdef HGCAL_LATENT_DEFRAMER_DOUBLE_BUF_EN
   logic                 wr_sel_q, rd_sel_q;
   logic [1:0]           full;
   logic [FRAME_W-1:0]   frame [2];

   // After completion the write target flips; it stays busy unless popped now
   assign tgt_busy_cpl  = full[~wr_sel_q] && !(pop && (rd_sel_q != wr_sel_q));
   // In HOLD both buffers are full and the write target is the oldest one
   assign tgt_free_hold = pop && (rd_sel_q == wr_sel_q);

   for (genvar g = 0; g < 2; g++) begin : g_buf
      hgcal_latent_frame_buf #(
         .LANE_W (LANE_W),
         .BEATS  (BEATS),
         .CNT_W  (CNT_W)
      ) u_buf (
         .clk        (clk),
         .rst        (rst),
         .wr_en_i    (wr_en && (wr_sel_q == 1'(g))),
         .wr_idx_i   (cnt_q),
         .wr_data_i  (s_data),
         .set_full_i (cpl && (wr_sel_q == 1'(g))),
         .clr_full_i (pop && (rd_sel_q == 1'(g))),
         .frame_o    (frame[g]),
         .full_o     (full[g])
      );
   end

   // Ping-pong pointers keep frames in arrival order
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
      end else begin
         if (cpl) wr_sel_q <= ~wr_sel_q;
         if (pop) rd_sel_q <= ~rd_sel_q;
      end
   end

   assign m_valid = full[rd_sel_q];
   assign m_data  = frame[rd_sel_q];
`else
   assign tgt_busy_cpl  = 1'b1;
   assign tgt_free_hold = pop;

   hgcal_latent_frame_buf #(
      .LANE_W (LANE_W),
      .BEATS  (BEATS),
      .CNT_W  (CNT_W)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (wr_en),
      .wr_idx_i   (cnt_q),
      .wr_data_i  (s_data),
      .set_full_i (cpl),
      .clr_full_i (pop),
      .frame_o    (m_data),
      .full_o     (m_valid)
   );
`endif

   // Next-state, beat-store and framing-error decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      cpl     = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE, FILL: begin
            if (acc) begin
               if (at_last) begin
                  cnt_d = '0;
                  if (s_last) begin
                     wr_en   = 1'b1;
                     cpl     = 1'b1;
                     state_d = tgt_busy_cpl ? HOLD : IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = RESYNC;
                  end
               end else if (s_last) begin
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  wr_en   = 1'b1;
                  cnt_d   = cnt_q + 1'b1;
                  state_d = FILL;
               end
            end
         end
         HOLD: begin
            if (tgt_free_hold) state_d = IDLE;
         end
         RESYNC: begin
            if (acc && s_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter, ready, error pulse and saturating error count
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rdy_q     <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdy_q   <= (state_d != HOLD);
         err_q   <= err_d;
         if (err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   assign s_ready   = rdy_q;
   assign frame_err = err_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_hgcal_latent_deframer.sv
// Directed bench for hgcal_latent_deframer at default parameters.
module tb_hgcal_latent_deframer;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        s_last;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        frame_err;
   logic [7:0]  err_count;

   int checks   = 0;
   int failures = 0;

`ifdef HGCAL_LATENT_DEFRAMER_DOUBLE_BUF_EN
   localparam logic EXP_RDY_HOLD = 1'b1;
`else
   localparam logic EXP_RDY_HOLD = 1'b0;
`endif

   hgcal_latent_deframer dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .frame_err (frame_err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until accepted (bounded wait)
   task automatic send(input logic [7:0] d, input logic l);
      int n;
      n       = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (!s_ready && n < 50) begin
         cyc();
         n++;
      end
      chk("s_ready_wait", 64'(n < 50), 64'd1);
      cyc();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   initial begin
      rst     = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      repeat (3) cyc();
      chk("rst_s_ready",   64'(s_ready),   64'd0);
      chk("rst_m_valid",   64'(m_valid),   64'd0);
      chk("rst_m_data",    64'(m_data),    64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      rst = 1'b1;
      cyc();
      chk("post_rst_s_ready", 64'(s_ready), 64'd1);

      // Single frame with consumer ready
      m_ready = 1'b1;
      send(8'h1B, 1'b0);
      send(8'hE4, 1'b0);
      send(8'h00, 1'b0);
      chk("f1_no_early_valid", 64'(m_valid), 64'd0);
      send(8'hFF, 1'b1);
      chk("f1_m_valid",   64'(m_valid),     64'd1);
      chk("f1_m_data",    64'(m_data),      64'hFF00E41B);
      chk("f1_neuron0",   64'(m_data[1:0]), 64'd3);
      chk("f1_frame_err", 64'(frame_err),   64'd0);
      cyc();
      chk("f1_m_valid_fall", 64'(m_valid), 64'd0);

      // Back-pressure: held frame stays stable
      m_ready = 1'b0;
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b1);
      chk("bp_m_valid", 64'(m_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         chk("bp_m_data",  64'(m_data),  64'h44332211);
         chk("bp_m_valid_hold", 64'(m_valid), 64'd1);
         chk("bp_s_ready", 64'(s_ready), 64'(EXP_RDY_HOLD));
         cyc();
      end
      m_ready = 1'b1;
      cyc();
      chk("bp_release_m_valid", 64'(m_valid), 64'd0);
      chk("bp_release_s_ready", 64'(s_ready), 64'd1);

      // Early last on beat 1
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b1);
      chk("early_frame_err", 64'(frame_err), 64'd1);
      chk("early_err_count", 64'(err_count), 64'd1);
      chk("early_m_valid",   64'(m_valid),   64'd0);
      cyc();
      chk("early_err_pulse_end", 64'(frame_err), 64'd0);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      send(8'h04, 1'b1);
      chk("early_next_valid", 64'(m_valid), 64'd1);
      chk("early_next_data",  64'(m_data),  64'h04030201);
      cyc();

      // Missing last: six beats, last only on beat 5
      send(8'h10, 1'b0);
      send(8'h20, 1'b0);
      send(8'h30, 1'b0);
      send(8'h40, 1'b0);
      chk("miss_frame_err", 64'(frame_err), 64'd1);
      chk("miss_err_count", 64'(err_count), 64'd2);
      send(8'h50, 1'b0);
      chk("miss_pulse_end", 64'(frame_err), 64'd0);
      send(8'h60, 1'b1);
      chk("miss_drop_valid", 64'(m_valid),   64'd0);
      chk("miss_no_2nd_err", 64'(frame_err), 64'd0);
      chk("miss_count_hold", 64'(err_count), 64'd2);
      send(8'hA1, 1'b0);
      send(8'hB2, 1'b0);
      send(8'hC3, 1'b0);
      send(8'hD4, 1'b1);
      chk("miss_next_valid", 64'(m_valid), 64'd1);
      chk("miss_next_data",  64'(m_data),  64'hD4C3B2A1);
      cyc();

      // Saturation: 300 single-beat early-last errors
      for (int i = 0; i < 300; i++) send(8'(i), 1'b1);
      chk("sat_err_count", 64'(err_count), 64'd255);
      chk("sat_m_valid",   64'(m_valid),   64'd0);

      // Reset mid-frame
      send(8'h99, 1'b0);
      send(8'h88, 1'b0);
      rst = 1'b0;
      cyc();
      chk("mid_rst_err_count", 64'(err_count), 64'd0);
      chk("mid_rst_m_valid",   64'(m_valid),   64'd0);
      chk("mid_rst_s_ready",   64'(s_ready),   64'd0);
      chk("mid_rst_frame_err", 64'(frame_err), 64'd0);
      rst = 1'b1;
      cyc();
      chk("mid_rst_release_rdy", 64'(s_ready), 64'd1);
      send(8'h5A, 1'b0);
      send(8'h6B, 1'b0);
      send(8'h7C, 1'b0);
      send(8'h8D, 1'b1);
      chk("post_rst_valid",     64'(m_valid),   64'd1);
      chk("post_rst_data",      64'(m_data),    64'h8D7C6B5A);
      chk("post_rst_no_err",    64'(err_count), 64'd0);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
